stack_bus_packet_arbiter: RTL and testbench

STACK_BUS_PACKET_ARBITER -- requirements
Module: stack_bus_packet_arbiter

---
 rtl/stack_bus_packet_arbiter_pkg.sv | 18 +
 rtl/stack_bus_arb_fifo.sv | 49 ++++
 rtl/stack_bus_packet_arbiter.sv | 151 +++++++++++++++
 tb/tb_stack_bus_packet_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_bus_packet_arbiter_pkg.sv
// Shared constants for the stack bus packet arbiter: FSM encodings, arbitration
// modes and the source-id width helper.
package stack_bus_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam logic MODE_ROUND_ROBIN = 1'b0;
  localparam logic MODE_FIXED_PRIO  = 1'b1;

  // Width of a source index, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stack_bus_arb_fifo.sv
// Per-source beat FIFO. Occupancy is registered so full/empty are clean flops;
// the caller guarantees no push when full and no pop when empty.
module stack_bus_arb_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_poweron,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule

// File: rtl/stack_bus_packet_arbiter.sv
// Packet arbiter: NUM_SRC beat FIFOs merged onto one stack bus, whole packets at
// a time, round-robin or fixed priority, with orphan (no-sop) beats dropped.
module stack_bus_packet_arbiter
  import stack_bus_packet_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int SRC_ID_WIDTH = id_width(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  input  logic                          cfg__arb_mode,
  input  logic [NUM_SRC-1:0]            src__arb__valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src__arb__data,
  input  logic [NUM_SRC-1:0]            src__arb__sop,
  input  logic [NUM_SRC-1:0]            src__arb__eop,
  output logic [NUM_SRC-1:0]            arb__src__ready,
  output logic                          arb__bus__valid,
  output logic [DATA_WIDTH-1:0]         arb__bus__data,
  output logic                          arb__bus__sop,
  output logic                          arb__bus__eop,
  output logic [SRC_ID_WIDTH-1:0]       arb__bus__src_id,
  input  logic                          bus__arb__ready,
  output logic [15:0]                   arb__stat__drop_cnt,
  output logic                          dbg_state
);

  // Handshakes: a beat transfers on the rising edge where valid & ready are both
  // high; valid never waits on ready, and a stalled beat holds all its fields.

  localparam int FW = DATA_WIDTH + 2;
  localparam logic [SRC_ID_WIDTH-1:0] LAST_IDX  = SRC_ID_WIDTH'(NUM_SRC - 1);
  localparam logic [SRC_ID_WIDTH:0]   NUM_SRC_W = (SRC_ID_WIDTH+1)'(NUM_SRC);

  logic [NUM_SRC-1:0]    push, pop, empty, full, head_sop, head_eop, cand, orphan;
  logic [DATA_WIDTH-1:0] head_data [NUM_SRC];

  arb_state_t state, state_nxt;
  logic [SRC_ID_WIDTH-1:0] grant, grant_nxt, last_grant, last_grant_nxt;
  logic [SRC_ID_WIDTH-1:0] start, pick;
  logic [SRC_ID_WIDTH:0]   ofs, sum, drops;
  logic [NUM_SRC-1:0]      rot;
  logic                    found;
  logic [15:0]             drop_cnt, drop_cnt_nxt;
  logic [16:0]             drop_sum;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [FW-1:0] head;
    assign push[g] = src__arb__valid[g] & ~full[g];
    stack_bus_arb_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push          (push[g]),
      .push_data     ({src__arb__sop[g], src__arb__eop[g],
                       src__arb__data[g*DATA_WIDTH +: DATA_WIDTH]}),
      .pop           (pop[g]),
      .head          (head),
      .empty         (empty[g]),
      .full          (full[g])
    );
    assign head_sop[g]  = head[FW-1];
    assign head_eop[g]  = head[FW-2];
    assign head_data[g] = head[DATA_WIDTH-1:0];
  end

  // Ready comes from registered occupancy only, so a full FIFO stays closed
  // even in the cycle it is popped.
  assign arb__src__ready = ~full;
  assign cand   = ~empty & head_sop;
  assign orphan = ~empty & ~head_sop;

  // Rotate candidates so the search origin sits at bit 0, then priority encode.
  always_comb begin
    start = '0;
    if (cfg__arb_mode == MODE_ROUND_ROBIN && last_grant != LAST_IDX)
      start = last_grant + 1'b1;
    rot   = NUM_SRC'({cand, cand} >> start);
    found = 1'b0;
    ofs   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        ofs   = (SRC_ID_WIDTH+1)'(i);
      end
    end
    sum = {1'b0, start} + ofs;
    if (sum >= NUM_SRC_W) sum = sum - NUM_SRC_W;
    pick  = sum[SRC_ID_WIDTH-1:0];
    drops = '0;
    for (int i = 0; i < NUM_SRC; i++) drops = drops + (SRC_ID_WIDTH+1)'(orphan[i]);
  end

  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant;
    last_grant_nxt   = last_grant;
    drop_cnt_nxt     = drop_cnt;
    drop_sum         = '0;
    pop              = '0;
    arb__bus__valid  = 1'b0;
    arb__bus__data   = '0;
    arb__bus__sop    = 1'b0;
    arb__bus__eop    = 1'b0;
    arb__bus__src_id = '0;
    case (state)
      ST_IDLE: begin
        pop          = orphan;
        drop_sum     = {1'b0, drop_cnt} + 17'(drops);
        drop_cnt_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (found) begin
          grant_nxt = pick;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        arb__bus__valid  = ~empty[grant];
        arb__bus__data   = head_data[grant];
        arb__bus__sop    = head_sop[grant];
        arb__bus__eop    = head_eop[grant];
        arb__bus__src_id = grant;
        if (~empty[grant] && bus__arb__ready) begin
          pop[grant] = 1'b1;
          if (head_eop[grant]) begin
            state_nxt      = ST_IDLE;
            last_grant_nxt = grant;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_IDX;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      drop_cnt   <= drop_cnt_nxt;
    end
  end

  assign arb__stat__drop_cnt = drop_cnt;
  assign dbg_state           = state;

endmodule

// File: tb/tb_stack_bus_packet_arbiter.sv
// Directed bench for stack_bus_packet_arbiter: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_stack_bus_packet_arbiter;
  import stack_bus_packet_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset_poweron;
  logic            cfg__arb_mode;
  logic [NS-1:0]   src__arb__valid;
  logic [NS*DW-1:0] src__arb__data;
  logic [NS-1:0]   src__arb__sop;
  logic [NS-1:0]   src__arb__eop;
  logic [NS-1:0]   arb__src__ready;
  logic            arb__bus__valid;
  logic [DW-1:0]   arb__bus__data;
  logic            arb__bus__sop;
  logic            arb__bus__eop;
  logic [1:0]      arb__bus__src_id;
  logic            bus__arb__ready;
  logic [15:0]     arb__stat__drop_cnt;
  logic            dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [67:0] exp_q[$];
  logic [67:0] obs_q[$];
  int          obs_cyc[$];

  stack_bus_packet_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .reset_poweron       (reset_poweron),
    .cfg__arb_mode       (cfg__arb_mode),
    .src__arb__valid     (src__arb__valid),
    .src__arb__data      (src__arb__data),
    .src__arb__sop       (src__arb__sop),
    .src__arb__eop       (src__arb__eop),
    .arb__src__ready     (arb__src__ready),
    .arb__bus__valid     (arb__bus__valid),
    .arb__bus__data      (arb__bus__data),
    .arb__bus__sop       (arb__bus__sop),
    .arb__bus__eop       (arb__bus__eop),
    .arb__bus__src_id    (arb__bus__src_id),
    .bus__arb__ready     (bus__arb__ready),
    .arb__stat__drop_cnt (arb__stat__drop_cnt),
    .dbg_state           (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor: every accepted bus beat with its cycle stamp
  always @(negedge clk) begin
    if (reset_poweron === 1'b0 && arb__bus__valid === 1'b1 && bus__arb__ready === 1'b1) begin
      obs_q.push_back({arb__bus__src_id, arb__bus__sop, arb__bus__eop, arb__bus__data});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input int s, input int p, input int b);
    return 64'hDA7A_0000_0000_0000 | (64'(s) << 16) | (64'(p) << 8) | 64'(b);
  endfunction

  function automatic logic [67:0] eb(input int s, input logic sp, input logic ep,
                                     input logic [63:0] d);
    return {2'(s), sp, ep, d};
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    src__arb__valid = '0;
    src__arb__sop   = '0;
    src__arb__eop   = '0;
  endtask

  task automatic set_beat(input int s, input logic sp, input logic ep, input logic [63:0] d);
    src__arb__valid[s]        = 1'b1;
    src__arb__sop[s]          = sp;
    src__arb__eop[s]          = ep;
    src__arb__data[s*DW +: DW] = d;
  endtask

  task automatic push_beat(input int s, input logic sp, input logic ep, input logic [63:0] d);
    set_beat(s, sp, ep, d);
    tick();
    clr();
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_beats"}, 72'(obs_q.size()), 72'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, 72'(obs_q.pop_front()), 72'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    reset_poweron   = 1'b1;
    cfg__arb_mode   = MODE_ROUND_ROBIN;
    src__arb__data  = '0;
    bus__arb__ready = 1'b0;
    clr();

    // Reset state
    run(2);
    @(negedge clk);
    check("rst_valid",  72'(arb__bus__valid), 72'(0));
    check("rst_data",   72'(arb__bus__data), 72'(0));
    check("rst_sopeop", 72'({arb__bus__sop, arb__bus__eop}), 72'(0));
    check("rst_src_id", 72'(arb__bus__src_id), 72'(0));
    check("rst_drop",   72'(arb__stat__drop_cnt), 72'(0));
    check("rst_state",  72'(dbg_state), 72'(0));
    tick();
    reset_poweron = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_ready", 72'(arb__src__ready), 72'(4'b1111));
    check("post_rst_valid", 72'(arb__bus__valid), 72'(0));

    // Round-robin: four 3-beat packets loaded behind a stalled bus
    cfg__arb_mode   = MODE_ROUND_ROBIN;
    bus__arb__ready = 1'b0;
    tick();
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < 3; b++) begin
        push_beat(s, b == 0, b == 2, mk(s, 0, b));
        exp_q.push_back(eb(s, b == 0, b == 2, mk(s, 0, b)));
      end
    end
    check("rr_held", 72'(obs_q.size()), 72'(0));
    bus__arb__ready = 1'b1;
    run(25);
    check("rr_gap_beats", 72'(obs_cyc.size()), 72'(12));
    if (obs_cyc.size() == 12) begin
      for (int k = 1; k < 12; k++)
        check("rr_gap", 72'(obs_cyc[k] - obs_cyc[k-1]), 72'((k % 3 == 0) ? 2 : 1));
    end
    check_stream("rr");

    // Minimum latency: push at cycle N, valid at N+2, idle after the eop
    push_beat(0, 1'b1, 1'b1, mk(0, 1, 0));
    @(negedge clk);
    check("lat_n1_valid", 72'(arb__bus__valid), 72'(0));
    tick();
    @(negedge clk);
    check("lat_n2_valid", 72'(arb__bus__valid), 72'(1));
    check("lat_n2_beat",  72'({arb__bus__src_id, arb__bus__sop, arb__bus__eop, arb__bus__data}),
          72'(eb(0, 1'b1, 1'b1, mk(0, 1, 0))));
    check("lat_n2_state", 72'(dbg_state), 72'(1));
    tick();
    @(negedge clk);
    check("lat_idle_valid", 72'(arb__bus__valid), 72'(0));
    check("lat_idle_data",  72'(arb__bus__data), 72'(0));
    check("lat_idle_state", 72'(dbg_state), 72'(0));
    obs_q.delete();
    obs_cyc.delete();

    // Fixed priority: src0 beats src2; a late src0 packet waits for src2's eop
    cfg__arb_mode = MODE_FIXED_PRIO;
    tick();
    set_beat(2, 1'b1, 1'b0, mk(2, 2, 0));
    set_beat(0, 1'b1, 1'b0, mk(0, 2, 0));
    tick();
    clr();
    set_beat(2, 1'b0, 1'b1, mk(2, 2, 1));
    set_beat(0, 1'b0, 1'b1, mk(0, 2, 1));
    tick();
    clr();
    run(3);
    bus__arb__ready = 1'b0;
    push_beat(0, 1'b1, 1'b1, mk(0, 3, 0));
    run(3);
    @(negedge clk);
    check("fixed_hold_src", 72'({arb__bus__valid, arb__bus__src_id, arb__bus__sop}),
          72'({1'b1, 2'd2, 1'b1}));
    tick();
    bus__arb__ready = 1'b1;
    run(10);
    exp_q.push_back(eb(0, 1'b1, 1'b0, mk(0, 2, 0)));
    exp_q.push_back(eb(0, 1'b0, 1'b1, mk(0, 2, 1)));
    exp_q.push_back(eb(2, 1'b1, 1'b0, mk(2, 2, 0)));
    exp_q.push_back(eb(2, 1'b0, 1'b1, mk(2, 2, 1)));
    exp_q.push_back(eb(0, 1'b1, 1'b1, mk(0, 3, 0)));
    check_stream("fixed");

    // Backpressure mid-packet: bus fields frozen, src1 FIFO fills and closes
    cfg__arb_mode = MODE_ROUND_ROBIN;
    push_beat(1, 1'b1, 1'b0, mk(1, 4, 0));
    push_beat(1, 1'b0, 1'b0, mk(1, 4, 1));
    tick();
    bus__arb__ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) set_beat(1, 1'b0, k == 2, mk(1, 4, k + 2));
      @(negedge clk);
      check("bp_stable", 72'({arb__bus__valid, arb__bus__src_id, arb__bus__sop, arb__bus__eop,
                              arb__bus__data}), 72'({1'b1, eb(1, 1'b0, 1'b0, mk(1, 4, 1))}));
      if (k == 3) check("bp_full_ready", 72'(arb__src__ready), 72'(4'b1101));
      tick();
      clr();
    end
    bus__arb__ready = 1'b1;
    @(negedge clk);
    check("bp_full_pop_ready", 72'(arb__src__ready), 72'(4'b1101));
    tick();
    @(negedge clk);
    check("bp_reopen_ready", 72'(arb__src__ready), 72'(4'b1111));
    run(8);
    exp_q.push_back(eb(1, 1'b1, 1'b0, mk(1, 4, 0)));
    for (int b = 1; b < 5; b++) exp_q.push_back(eb(1, 1'b0, b == 4, mk(1, 4, b)));
    check_stream("bp");

    // Orphan beats ahead of a real packet are dropped and counted
    push_beat(1, 1'b0, 1'b0, mk(1, 5, 0));
    push_beat(1, 1'b0, 1'b0, mk(1, 5, 1));
    push_beat(1, 1'b1, 1'b0, mk(1, 6, 0));
    push_beat(1, 1'b0, 1'b1, mk(1, 6, 1));
    run(8);
    @(negedge clk);
    check("orphan_drop_cnt", 72'(arb__stat__drop_cnt), 72'(2));
    exp_q.push_back(eb(1, 1'b1, 1'b0, mk(1, 6, 0)));
    exp_q.push_back(eb(1, 1'b0, 1'b1, mk(1, 6, 1)));
    check_stream("orphan");

    // Reset during beat 2 of a 4-beat src3 packet discards the rest
    tick();
    for (int b = 0; b < 4; b++) push_beat(3, b == 0, b == 3, mk(3, 7, b));
    reset_poweron = 1'b1;
    @(negedge clk);
    check("mid_rst_beat", 72'({arb__bus__valid, arb__bus__data}), 72'({1'b1, mk(3, 7, 2)}));
    tick();
    reset_poweron = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 72'(arb__bus__valid), 72'(0));
    check("mid_rst_drop",  72'(arb__stat__drop_cnt), 72'(0));
    check("mid_rst_ready", 72'(arb__src__ready), 72'(4'b1111));
    check("mid_rst_eop",   72'({arb__bus__eop, arb__bus__data}), 72'(0));
    obs_q.delete();
    obs_cyc.delete();
    tick();
    push_beat(3, 1'b1, 1'b0, mk(3, 8, 0));
    push_beat(3, 1'b0, 1'b1, mk(3, 8, 1));
    run(8);
    exp_q.push_back(eb(3, 1'b1, 1'b0, mk(3, 8, 0)));
    exp_q.push_back(eb(3, 1'b0, 1'b1, mk(3, 8, 1)));
    check_stream("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
